// File: rtl/reg_file_mp.sv
// Multi-port register file: one acc/se write port, a single-outstanding load-return
// path with WAW kill tracking, and two registered read ports. REG_FILE_BYPASS_EN enables read forwarding.
module reg_file_mp #(
  parameter int WIDTH = 16,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lacc,
  input  logic [WIDTH-1:0] acc,
  input  logic             lse,
  input  logic [WIDTH-1:0] se,
  input  logic [AW-1:0]    wa,
  input  logic             ld_issue,
  input  logic [AW-1:0]    ld_dst,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] load,
  input  logic [AW-1:0]    ra0,
  input  logic [AW-1:0]    ra1,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic             busy0,
  output logic             busy1,
  output logic             ld_busy,
  output logic             issue_err
);

  localparam int unsigned NREG = 1 << AW;

  logic [WIDTH-1:0] regs [NREG];
  logic [AW-1:0]    pend_dst;
  logic             kill;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             issue_ok;
  logic             ret;
  logic             ld_wr;
  logic [AW-1:0]    pend_nxt;
  logic             busy_nxt;
  logic             kill_nxt;
  logic [WIDTH-1:0] rd0;
  logic [WIDTH-1:0] rd1;
  logic             pend0;
  logic             pend1;

  always_comb begin
    wr_en    = lacc | lse;
    wr_data  = lacc ? acc : se;
    issue_ok = ld_issue && (!ld_busy || ld_valid);
    ret      = ld_valid && ld_busy;
    // A same-cycle acc/se write to the load target wins over the returning data.
    ld_wr    = ret && !kill && !(wr_en && (wa == pend_dst));
    pend_nxt = pend_dst;
    busy_nxt = ld_busy;
    kill_nxt = kill;
    if (ret)
      busy_nxt = 1'b0;
    if (wr_en && ld_busy && (wa == pend_dst))
      kill_nxt = 1'b1;
    if (issue_ok) begin
      pend_nxt = ld_dst;
      busy_nxt = 1'b1;
      kill_nxt = 1'b0;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  always_comb begin
    rd0   = regs[ra0];
    rd1   = regs[ra1];
    if (ld_wr && (pend_dst == ra0))
      rd0 = load;
    if (ld_wr && (pend_dst == ra1))
      rd1 = load;
    if (wr_en && (wa == ra0))
      rd0 = wr_data;
    if (wr_en && (wa == ra1))
      rd1 = wr_data;
    pend0 = busy_nxt && !kill_nxt && (pend_nxt == ra0);
    pend1 = busy_nxt && !kill_nxt && (pend_nxt == ra1);
  end
`else
  always_comb begin
    rd0   = regs[ra0];
    rd1   = regs[ra1];
    pend0 = ld_busy && !kill && (pend_dst == ra0);
    pend1 = ld_busy && !kill && (pend_dst == ra1);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++)
        regs[i] <= '0;
      pend_dst  <= '0;
      ld_busy   <= 1'b0;
      kill      <= 1'b0;
      issue_err <= 1'b0;
      out0      <= '0;
      out1      <= '0;
      busy0     <= 1'b0;
      busy1     <= 1'b0;
    end else begin
      if (ld_wr)
        regs[pend_dst] <= load;
      if (wr_en)
        regs[wa] <= wr_data;
      pend_dst <= pend_nxt;
      ld_busy  <= busy_nxt;
      kill     <= kill_nxt;
      if (ld_issue && ld_busy && !ld_valid)
        issue_err <= 1'b1;
      out0  <= rd0;
      out1  <= rd1;
      busy0 <= pend0;
      busy1 <= pend1;
    end
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-register successor to the two-entry accumulator register file. It holds 2**AW registers of WIDTH bits. One write port is fed by the accumulator or the sign-extender. A separate load-return path has one outstanding memory load tracked by a pending scoreboard. Two registered read ports feed the datapath and stall logic.

## Interface
- WIDTH, 16: register and data width in bits.
- AW, 2: register address width; register count is 2**AW.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- lacc  in  1  write acc into register wa.
- acc  in  WIDTH  accumulator data.
- lse  in  1  write se into register wa.
- se  in  WIDTH  sign-extended immediate.
- wa  in  AW  write address for acc/se.
- ld_issue  in  1  reserve register ld_dst for a memory load.
- ld_dst  in  AW  destination of the issued load.
- ld_valid  in  1  load data returned on load.
- load  in  WIDTH  load return data.
- ra0, ra1  in  AW  read addresses.
- out0, out1  out  WIDTH  registered read data.
- busy0, busy1  out  1  registered "addressed register has a pending load".
- ld_busy  out  1  a load is outstanding.
- issue_err  out  1  sticky: ld_issue was rejected.

## Operation
- State:
  - regs[2**AW];
  - pend_dst (AW);
  - ld_busy;
  - kill: the pending load was overwritten;
  - issue_err.
- Write port: lacc has priority over lse; the data is acc or se and is written to regs[wa]. With neither asserted, the port is idle.
- Load issue:
  - Accepted when ld_issue=1 and either ld_busy=0 or ld_valid=1 in the same cycle (back-to-back).
  - On accept: pend_dst<=ld_dst, ld_busy<=1, kill<=0.
  - ld_issue while ld_busy=1 and ld_valid=0 is ignored and sets issue_err<=1. issue_err stays set until reset.
- Load return:
  - ld_valid with ld_busy=1 completes the load and clears ld_busy, unless a new issue is accepted in the same cycle.
  - load is written to regs[pend_dst] only if kill=0.
  - ld_valid with ld_busy=0 is ignored.
- WAW handling: an acc/se write to wa==pend_dst while ld_busy=1 sets kill<=1. The later load data is then dropped, while ld_busy still clears on return.
- Same-cycle acc/se write and load return to the same register: the acc/se value wins and the load is dropped.
- Pending bit for register r = ld_busy && !kill && pend_dst==r.
- Read ports: outN<=regs[raN] and busyN<=pending(raN). Without bypass, both use the pre-edge state.

## Timing
- Reset state, asynchronous and immediate: all regs=0, out0=out1=0, busy0=busy1=0, ld_busy=0, kill=0, issue_err=0.
- Reset mid-load discards the outstanding load. An ld_valid arriving after reset release is ignored.
- Write latency: the value is visible in regs one edge after the write strobe.
- Read latency: one edge; outN updates on the edge after raN is presented.
- ld_busy rises on the edge that accepts ld_issue and falls on the edge of ld_valid.
- Minimum issue-to-return gap is one cycle. ld_valid in the same cycle as the accepting ld_issue belongs to the previous load.

## Configuration
- REG_FILE_BYPASS_EN defined:
  - Read ports forward same-cycle writes. outN takes the value written to raN this cycle: the winning acc/se write, else the accepted load return, else regs[raN].
  - busyN reflects the post-edge pending state.
- Not defined: reads return the pre-edge register contents and pre-edge pending state, with no forwarding logic.

## Test plan
- Reset, then ra0=0..3 -> out0=0 and busy0=0 for every address; ld_busy=0; issue_err=0.
- lacc=1, lse=1, wa=2, acc=16'h1234, se=16'hFFF0; next cycle ra0=2 -> out0=16'h1234 one edge later. With bypass, reading ra0=2 in the write cycle gives 16'h1234 at that edge; without bypass it gives 0.
- ld_issue with ld_dst=1, ra1=1 -> busy1=1 and ld_busy=1. Three cycles later, ld_valid with load=16'hBEEF -> regs[1]=16'hBEEF and busy1=0.
- ld_issue with ld_dst=3, then lse with wa=3 and se=16'h0007, then ld_valid with load=16'hAAAA -> regs[3]=16'h0007 and ld_busy=0.
- ld_issue(dst 0), ld_issue(dst 1) while busy -> issue_err=1 and pend_dst stays 0. Then ld_valid together with ld_issue(dst 2) -> regs[0] is loaded and a new load is pending on register 2.
- Assert rst while ld_busy=1, then ld_valid after release -> no register changes and ld_busy=0.
